instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Boot-time writer for the word-addressed instruction memory, which the core reads as mem[A[31:2]].
- Receives a byte stream through a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Emits one write per word into the memory's write port.
- Holds the core in reset until the whole image is loaded.

Parameters:
DEPTH, 1024, instruction memory depth in words; words at index DEPTH or above are not written.
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word-aligned.

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE or DONE
s_valid  input  1  byte stream valid
s_data  input  8  byte stream data
s_ready  output  1  loader accepts s_data this cycle
we  output  1  instruction memory write enable, one-cycle pulse per word
waddr  output  32  byte address of the word being written; bits [1:0] are always 0
wdata  output  32  assembled instruction word
core_rst  output  1  high holds the core in reset
done  output  1  load finished; sticky
err  output  1  declared word count exceeded DEPTH; sticky

Behaviour:
- Reset values (registered outputs): s_ready=0, we=0, waddr=0, wdata=0, core_rst=1, done=0, err=0; state=IDLE. Internal byte counter, word counter and length register all reset to 0.
- Byte transfer: a byte is accepted only on a cycle where s_valid & s_ready. s_ready is registered and depends only on state.
- Stream format:
  - Bytes 0-1: word count N, 16-bit little-endian.
  - Then N words, 4 bytes each, least-significant byte first.
- IDLE: s_ready=0. start -> LEN_LO.
- LEN_LO: s_ready=1. Accepted byte -> N[7:0], go to LEN_HI.
- LEN_HI: s_ready=1. Accepted byte -> N[15:8].
  - If N==0 -> DONE.
  - Otherwise -> BYTES; err is set if N > DEPTH.
- BYTES: s_ready=1. Each accepted byte shifts into wdata at position byte_cnt (byte_cnt 0..3).
  - When the 4th byte is accepted -> WRITE.
- WRITE: exactly one cycle.
  - s_ready=0.
  - we=1 only if word_cnt < DEPTH; otherwise the word is consumed but not written.
  - waddr = BASE_ADDR + 4*word_cnt; wdata holds the full word. Both stay stable while we=1.
  - word_cnt increments. If it reaches N -> DONE, else -> BYTES.
- Latency: we is high in the cycle immediately after the cycle in which the 4th byte of a word is accepted. Sustained throughput is one word per 5 cycles.
- DONE:
  - s_ready=0, done=1, core_rst=0 (deasserts on the cycle DONE is entered).
  - start -> LEN_LO, clears done and err, and sets core_rst=1 on the next edge.
- core_rst=1 in every state except DONE.
- Boundary rules:
  - start outside IDLE/DONE is ignored.
  - s_valid with s_ready=0 is ignored; no byte is consumed.
  - waddr does not wrap within a load: word_cnt is 16 bits, and writes stop at DEPTH.
  - N=65535 is legal.
  - rst mid-load aborts immediately: all outputs return to reset values, any partial word is discarded, and the memory keeps whatever was already written.
  - rst and start in the same cycle: rst wins.
- Arithmetic: waddr is computed as 32 bits and wraps modulo 2^32.

Test Plan:
1. rst, start, stream 02 00 | 03 A1 00 00 | B3 01 51 00
   -> two we pulses: waddr=0 wdata=32'h0000A103, then waddr=4 wdata=32'h005101B3; done=1 and core_rst=0 one cycle after the second we.
2. Same stream with s_valid toggled every other cycle
   -> identical writes and data; no byte lost or duplicated; s_ready never high in WRITE.
3. start, stream 00 00
   -> no we; done=1 and core_rst=0 on the edge after the second byte; err=0.
4. DEPTH=4, N=6, six distinct words
   -> err=1; exactly 4 we pulses with waddr 0,4,8,12; 24 data bytes consumed; done=1.
5. rst asserted after 2 data bytes of word 1, then a fresh start and a one-word load (01 00 | 13 06 50 02)
   -> outputs at reset values on the cycle after rst; the new load writes waddr=0 wdata=32'h02500613.
6. Start in DONE: after test 1, pulse start and load one word with BASE_ADDR=32'h100
   -> done drops, core_rst rises next cycle; single write waddr=32'h100; done re-asserts.

Source files
------------

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Boot-time writer for a word-addressed instruction memory. A byte stream
// (valid/ready) carries a 16-bit little-endian word count N followed by N
// little-endian 32-bit words. Each assembled word is emitted as a single
// write pulse. The core is held in reset until the whole image is loaded.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     one-cycle pulse, begins a load from IDLE or DONE
//   s_valid   byte stream valid
//   s_data    byte stream data
//   s_ready   loader accepts s_data this cycle (registered, state only)
//   we        memory write enable, one pulse per in-range word
//   waddr     byte address of the word being written (word aligned)
//   wdata     assembled instruction word
//   core_rst  high holds the core in reset (low only in DONE)
//   done      load finished
//   err       declared word count exceeded DEPTH
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_BYTES,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] len_q, len_d;
    logic        s_ready_q, s_ready_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        core_rst_q, core_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic [15:0] len_full;
    logic [15:0] word_cnt_inc;
    logic [31:0] wdata_shift;

    assign accept       = s_valid & s_ready_q;
    assign len_full     = {s_data, len_q[7:0]};
    assign word_cnt_inc = word_cnt_q + 16'd1;

    // Incoming byte lands in the lane selected by byte_cnt; other lanes hold.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_shift[gi*8 +: 8] = (byte_cnt_q == 2'(gi)) ? s_data
                                                                   : wdata_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 16'd0;
                    len_d      = 16'd0;
                    err_d      = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = s_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = s_data;
                    if (len_full == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BYTES;
                        err_d   = (32'(len_full) > DEPTH);
                    end
                end
            end
            S_BYTES: begin
                if (accept) begin
                    wdata_d    = wdata_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Address and enable are registered here so they are
                        // valid for the whole WRITE cycle.
                        state_d = S_WRITE;
                        we_d    = (32'(word_cnt_q) < DEPTH);
                        waddr_d = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_inc;
                state_d    = (word_cnt_inc == len_q) ? S_DONE : S_BYTES;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered copies of the next state so they line up
    // with the state they describe.
    always_comb begin
        s_ready_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_BYTES);
        core_rst_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 16'd0;
            len_q      <= 16'd0;
            s_ready_q  <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= 32'd0;
            wdata_q    <= 32'd0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            s_ready_q  <= s_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign core_rst = core_rst_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Two loaders share one input stream: dut_a uses the default DEPTH/BASE_ADDR,
// dut_b uses DEPTH=4, BASE_ADDR=0x100. Their handshakes are identical, so a
// single driver feeds both while each is checked against its own expected
// write list derived from the stream contents.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int unsigned DEPTH_B = 4;
    localparam logic [31:0] BASE_B  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, start, s_valid;
    logic [7:0]  s_data;
    logic        s_ready_a, we_a, core_rst_a, done_a, err_a;
    logic [31:0] waddr_a, wdata_a;
    logic        s_ready_b, we_b, core_rst_b, done_b, err_b;
    logic [31:0] waddr_b, wdata_b;

    always #5 clk = ~clk;

    instr_mem_loader dut_a (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .core_rst(core_rst_a), .done(done_a), .err(err_a)
    );

    instr_mem_loader #(.DEPTH(DEPTH_B), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .core_rst(core_rst_b), .done(done_b), .err(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt_a = 0;
    int we_cnt_b = 0;

    // Independent pulse counters catch extra or missing write pulses.
    always @(negedge clk) begin
        if (we_a === 1'b1) we_cnt_a <= we_cnt_a + 1;
        if (we_b === 1'b1) we_cnt_b <= we_cnt_b + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef logic [31:0] word_q_t[$];

    typedef struct {
        string          name;
        int             n;
        logic [5:0][31:0] words;
        int             gap_mode;   // 0: back-to-back, 1: every other cycle, 2: random
        bit             poke;       // pulse start mid-load (must be ignored)
        int             exp_we_a;
        int             exp_we_b;
        logic           exp_err_a;
        logic           exp_err_b;
    } vec_t;

    function automatic vec_t make_vec(input string name, input int n,
                                      input logic [31:0] w0, w1, w2, w3, w4, w5,
                                      input int gap_mode, input bit poke,
                                      input int ewa, input int ewb,
                                      input logic eea, input logic eeb);
        vec_t v;
        v.name = name; v.n = n;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2;
        v.words[3] = w3; v.words[4] = w4; v.words[5] = w5;
        v.gap_mode = gap_mode; v.poke = poke;
        v.exp_we_a = ewa; v.exp_we_b = ewb;
        v.exp_err_a = eea; v.exp_err_b = eeb;
        return v;
    endfunction

    // Present one byte and hold it until accepted; returns at posedge+1 of
    // the cycle following acceptance.
    task automatic send_byte(input logic [7:0] b, input int gaps);
        int waited;
        for (int g = 0; g < gaps; g++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        waited  = 0;
        while (s_ready_a !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (s_ready_a !== 1'b1) begin
            check("s_ready_timeout", {31'd0, s_ready_a}, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic run_load(input string name, input word_q_t words, input int gap_mode,
                            input bit poke, input int exp_we_a, input int exp_we_b,
                            input logic exp_err_a, input logic exp_err_b);
        logic [7:0] stream[$];
        int n, base_a, base_b, gaps, idx;
        n = words.size();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        foreach (words[i]) begin
            for (int j = 0; j < 4; j++) stream.push_back(words[i][j*8 +: 8]);
        end
        base_a = we_cnt_a;
        base_b = we_cnt_b;

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check({name, ":start_done"},     {31'd0, done_a},     32'd0);
        check({name, ":start_core_rst"}, {31'd0, core_rst_a}, 32'd1);
        check({name, ":start_err_b"},    {31'd0, err_b},      32'd0);
        check({name, ":start_s_ready"},  {31'd0, s_ready_a},  32'd1);

        for (int k = 0; k < stream.size(); k++) begin
            if (poke && k == 3) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            case (gap_mode)
                0:       gaps = 0;
                1:       gaps = 1;
                default: gaps = $urandom_range(0, 2);
            endcase
            send_byte(stream[k], gaps);
            if (k >= 2 && ((k - 2) % 4) == 3) begin
                idx = (k - 2) / 4;
                $display("%s word %0d: we_a=%b waddr_a=%h wdata_a=%h we_b=%b waddr_b=%h",
                         name, idx, we_a, waddr_a, wdata_a, we_b, waddr_b);
                check({name, ":we_a"},       {31'd0, we_a},       32'd1);
                check({name, ":waddr_a"},    waddr_a,             32'(idx * 4));
                check({name, ":wdata_a"},    wdata_a,             words[idx]);
                check({name, ":s_ready_wr"}, {31'd0, s_ready_a},  32'd0);
                check({name, ":core_rst_wr"},{31'd0, core_rst_a}, 32'd1);
                check({name, ":we_b"},       {31'd0, we_b},       {31'd0, idx < int'(DEPTH_B)});
                if (idx < int'(DEPTH_B)) begin
                    check({name, ":waddr_b"}, waddr_b, BASE_B + 32'(idx * 4));
                    check({name, ":wdata_b"}, wdata_b, words[idx]);
                end
            end
        end
        if (n > 0) begin
            @(posedge clk); #1;
        end
        check({name, ":done_a"},     {31'd0, done_a},     32'd1);
        check({name, ":core_rst_a"}, {31'd0, core_rst_a}, 32'd0);
        check({name, ":done_b"},     {31'd0, done_b},     32'd1);
        check({name, ":core_rst_b"}, {31'd0, core_rst_b}, 32'd0);
        check({name, ":s_ready_done"},{31'd0, s_ready_a}, 32'd0);
        @(negedge clk);
        check({name, ":we_count_a"}, 32'(we_cnt_a - base_a), 32'(exp_we_a));
        check({name, ":we_count_b"}, 32'(we_cnt_b - base_b), 32'(exp_we_b));
        check({name, ":err_a"},      {31'd0, err_a},       {31'd0, exp_err_a});
        check({name, ":err_b"},      {31'd0, err_b},       {31'd0, exp_err_b});
        $display("%s: N=%0d writes_a=%0d writes_b=%0d err_a=%b err_b=%b done=%b",
                 name, n, we_cnt_a - base_a, we_cnt_b - base_b, err_a, err_b, done_a);
    endtask

    task automatic check_reset_values(input string name);
        check({name, ":s_ready"},  {31'd0, s_ready_a},  32'd0);
        check({name, ":we"},       {31'd0, we_a},       32'd0);
        check({name, ":waddr"},    waddr_a,             32'd0);
        check({name, ":wdata"},    wdata_a,             32'd0);
        check({name, ":core_rst"}, {31'd0, core_rst_a}, 32'd1);
        check({name, ":done"},     {31'd0, done_a},     32'd0);
        check({name, ":err"},      {31'd0, err_a},      32'd0);
        check({name, ":err_b"},    {31'd0, err_b},      32'd0);
        check({name, ":wdata_b"},  wdata_b,             32'd0);
    endtask

    vec_t    vecs[6];
    word_q_t wq;

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0;

        vecs[0] = make_vec("t1_two_words", 2, 32'h0000A103, 32'h005101B3, 0, 0, 0, 0,
                           0, 0, 2, 2, 1'b0, 1'b0);
        vecs[1] = make_vec("t2_toggled",   2, 32'h0000A103, 32'h005101B3, 0, 0, 0, 0,
                           1, 0, 2, 2, 1'b0, 1'b0);
        vecs[2] = make_vec("t3_empty",     0, 0, 0, 0, 0, 0, 0,
                           0, 0, 0, 0, 1'b0, 1'b0);
        vecs[3] = make_vec("t4_overflow",  6, 32'h11111111, 32'h22222222, 32'h33333333,
                           32'h44444444, 32'h55555555, 32'h66666666,
                           0, 0, 6, 4, 1'b0, 1'b1);
        vecs[4] = make_vec("t6_from_done", 1, 32'h00100093, 0, 0, 0, 0, 0,
                           0, 0, 1, 1, 1'b0, 1'b0);
        vecs[5] = make_vec("t7_start_ign", 3, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 0, 0, 0,
                           2, 1, 3, 3, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // s_valid in IDLE must not be taken.
        s_valid = 1'b1; s_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_s_ready", {31'd0, s_ready_a}, 32'd0);
        end
        check("idle_core_rst", {31'd0, core_rst_a}, 32'd1);
        s_valid = 1'b0;

        // Table-driven loads.
        for (int v = 0; v < 6; v++) begin
            wq.delete();
            for (int i = 0; i < vecs[v].n; i++) wq.push_back(vecs[v].words[i]);
            run_load(vecs[v].name, wq, vecs[v].gap_mode, vecs[v].poke,
                     vecs[v].exp_we_a, vecs[v].exp_we_b, vecs[v].exp_err_a, vecs[v].exp_err_b);
        end

        // Reset mid-load after two data bytes, with start in the same cycle.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midload_rst");
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_beats_start", {31'd0, s_ready_a}, 32'd0);
        wq.delete();
        wq.push_back(32'h02500613);
        run_load("t5_after_rst", wq, 0, 0, 1, 1, 1'b0, 1'b0);

        // Randomized loads against the stream model.
        for (int r = 0; r < 8; r++) begin
            int n;
            string nm;
            n = $urandom_range(0, 7);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            nm = $sformatf("rand%0d", r);
            run_load(nm, wq, 2, 0, n, (n < int'(DEPTH_B)) ? n : int'(DEPTH_B),
                     1'b0, n > int'(DEPTH_B));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
